// File: rtl/proc_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : proc_mem_responder_if
//  Description : Request/response stream bundle between a processor memory
//                port (master) and the memory responder (slave).
//                  req_*  : val/rdy request stream (type, tag, addr, len, data)
//                  resp_* : val/rdy response stream (echoed fields + data)
//                  err    : sticky error flag from the responder
//  Revision    : 1.0  initial release
// ============================================================================
interface proc_mem_responder_if;
    logic        req_val;
    logic        req_rdy;
    logic [2:0]  req_type;
    logic [7:0]  req_opaque;
    logic [31:0] req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_data;

    logic        resp_val;
    logic        resp_rdy;
    logic [2:0]  resp_type;
    logic [7:0]  resp_opaque;
    logic [1:0]  resp_len;
    logic [31:0] resp_data;

    logic        err;

    modport master (
        output req_val, req_type, req_opaque, req_addr, req_len, req_data,
        output resp_rdy,
        input  req_rdy,
        input  resp_val, resp_type, resp_opaque, resp_len, resp_data,
        input  err
    );

    modport slave (
        input  req_val, req_type, req_opaque, req_addr, req_len, req_data,
        input  resp_rdy,
        output req_rdy,
        output resp_val, resp_type, resp_opaque, resp_len, resp_data,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/proc_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : proc_mem_responder
//  Description : Single-port memory responder. Accepts val/rdy requests,
//                performs word/subword reads and writes on an internal array
//                at the accept edge, and returns in-order responses after a
//                fixed latency through a credit-limited response queue.
//  Ports       : clk     - clock, all state on rising edge
//                reset_n - asynchronous active-low reset
//                bus     - proc_mem_responder_if.slave (request stream,
//                          response stream, sticky err)
//  Revision    : 1.0  initial release
// ============================================================================
module proc_mem_responder #(
    parameter int p_mem_words    = 256,
    parameter int p_latency      = 1,
    parameter int p_resp_q_depth = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    proc_mem_responder_if.slave   bus
);

    localparam int c_aw  = $clog2(p_mem_words);
    localparam int c_qaw = (p_resp_q_depth > 1) ? $clog2(p_resp_q_depth) : 1;
    localparam int c_cw  = $clog2(p_resp_q_depth + 1);

    localparam logic [c_cw-1:0]  c_depth = c_cw'(p_resp_q_depth);
    localparam logic [c_cw-1:0]  c_cone  = c_cw'(1);
    localparam logic [c_qaw-1:0] c_qlast = c_qaw'(p_resp_q_depth - 1);
    localparam logic [c_qaw-1:0] c_qone  = c_qaw'(1);

    localparam logic [2:0] c_read   = 3'd0;
    localparam logic [2:0] c_write  = 3'd1;
    localparam logic [2:0] c_winit  = 3'd2;

    typedef struct packed {
        logic [2:0]  rtype;
        logic [7:0]  opaque;
        logic [1:0]  len;
        logic [31:0] data;
    } resp_t;

    // Storage
    logic [31:0]      mem_q [p_mem_words];
    resp_t            rq_q  [p_resp_q_depth];
    logic [c_qaw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_qaw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_cw-1:0]  qcnt_q, qcnt_d;
    logic [c_cw-1:0]  credit_q, credit_d;
    logic             err_q, err_d;

    // Request decode
    logic             w_acc;
    logic             w_pop;
    logic [c_aw-1:0]  w_idx;
    logic [1:0]       w_off;
    logic [2:0]       w_nbytes;
    logic             w_bad;
    logic [3:0]       w_base_lanes;
    logic [31:0]      w_base_mask;
    logic [31:0]      w_lane_mask;
    logic [31:0]      w_word;
    logic [31:0]      w_rdata;
    logic [31:0]      w_wword;
    logic             w_is_wr;
    resp_t            w_acc_entry;
    logic             w_push;
    resp_t            w_push_entry;
    resp_t            w_head;
    logic             w_unused_addr_bits;

    // Address bits above the array index wrap silently.
    assign w_unused_addr_bits = ^bus.req_addr[31:c_aw+2];

    // Ready comes from the registered credit count only, so a response
    // handshake cannot free a slot for a same-cycle accept.
    assign bus.req_rdy = reset_n & (credit_q < c_depth);
    assign w_acc       = bus.req_val & bus.req_rdy;
    assign w_pop       = bus.resp_val & bus.resp_rdy;
    assign w_idx       = bus.req_addr[c_aw+1:2];

    always_comb begin
        w_off    = bus.req_addr[1:0];
        w_nbytes = (bus.req_len == 2'd0) ? 3'd4 : {1'b0, bus.req_len};
        w_bad    = (bus.req_type >= 3'd3) || (({1'b0, w_off} + w_nbytes) > 3'd4);

        case (bus.req_len)
            2'd1:    w_base_lanes = 4'b0001;
            2'd2:    w_base_lanes = 4'b0011;
            2'd3:    w_base_lanes = 4'b0111;
            default: w_base_lanes = 4'b1111;
        endcase
        for (int b = 0; b < 4; b++) begin
            w_base_mask[8*b +: 8] = {8{w_base_lanes[b]}};
        end

        // Subword access: lane mask slides up by the byte offset; reads
        // slide back down so the result is right-justified.
        w_lane_mask = w_base_mask << {w_off, 3'b000};
        w_word      = mem_q[w_idx];
        w_rdata     = (w_word >> {w_off, 3'b000}) & w_base_mask;
        w_wword     = (w_word & ~w_lane_mask)
                    | ((bus.req_data << {w_off, 3'b000}) & w_lane_mask);
        w_is_wr     = !w_bad && ((bus.req_type == c_write) || (bus.req_type == c_winit));

        w_acc_entry.rtype  = bus.req_type;
        w_acc_entry.opaque = bus.req_opaque;
        w_acc_entry.len    = bus.req_len;
        w_acc_entry.data   = (!w_bad && (bus.req_type == c_read)) ? w_rdata : 32'd0;
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (w_acc && w_is_wr) begin
            mem_q[w_idx] <= w_wword;
        end
    end

    // Fixed-latency delay line between the access and the response queue.
    generate
        if (p_latency == 1) begin : g_pipe_bypass
            assign w_push       = w_acc;
            assign w_push_entry = w_acc_entry;
        end else begin : g_pipe
            logic [p_latency-2:0] pv_q;
            resp_t                pd_q [p_latency-1];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pv_q <= '0;
                end else begin
                    pv_q[0] <= w_acc;
                    for (int s = 1; s < p_latency - 1; s++) begin
                        pv_q[s] <= pv_q[s-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                pd_q[0] <= w_acc_entry;
                for (int s = 1; s < p_latency - 1; s++) begin
                    pd_q[s] <= pd_q[s-1];
                end
            end

            assign w_push       = pv_q[p_latency-2];
            assign w_push_entry = pd_q[p_latency-2];
        end
    endgenerate

    // Queue/credit next state. Credits cover every entry in the pipe and the
    // queue, so a push always finds space.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        qcnt_d   = qcnt_q;
        credit_d = credit_q;
        err_d    = err_q | (w_acc & w_bad);

        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == c_qlast) ? '0 : rd_ptr_q + c_qone;
        end
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == c_qlast) ? '0 : wr_ptr_q + c_qone;
        end

        case ({w_push, w_pop})
            2'b10:   qcnt_d = qcnt_q + c_cone;
            2'b01:   qcnt_d = qcnt_q - c_cone;
            default: qcnt_d = qcnt_q;
        endcase

        case ({w_acc, w_pop})
            2'b10:   credit_d = credit_q + c_cone;
            2'b01:   credit_d = credit_q - c_cone;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            qcnt_q   <= '0;
            credit_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            qcnt_q   <= qcnt_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            rq_q[wr_ptr_q] <= w_push_entry;
        end
    end

    // Fields are forced to zero whenever no response is presented, which
    // also covers the reset window.
    assign w_head          = rq_q[rd_ptr_q];
    assign bus.resp_val    = (qcnt_q != '0);
    assign bus.resp_type   = bus.resp_val ? w_head.rtype  : 3'd0;
    assign bus.resp_opaque = bus.resp_val ? w_head.opaque : 8'd0;
    assign bus.resp_len    = bus.resp_val ? w_head.len    : 2'd0;
    assign bus.resp_data   = bus.resp_val ? w_head.data   : 32'd0;
    assign bus.err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_proc_mem_responder
//  Description : Directed self-checking bench for proc_mem_responder with a
//                reference byte-lane memory model and an in-order response
//                scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_proc_mem_responder;

    localparam int c_words = 256;
    localparam int c_lat   = 2;
    localparam int c_depth = 3;

    localparam logic [2:0] c_read  = 3'd0;
    localparam logic [2:0] c_write = 3'd1;

    typedef struct packed {
        logic [2:0]  t;
        logic [7:0]  o;
        logic [1:0]  l;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    proc_mem_responder_if bus();

    proc_mem_responder #(
        .p_mem_words    (c_words),
        .p_latency      (c_lat),
        .p_resp_q_depth (c_depth)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t        sb [$];
    logic [31:0] mdl [c_words];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-at-a-time access on a word array.
    function automatic logic [31:0] model(input logic [2:0] t, input logic [31:0] a,
                                          input logic [1:0] l, input logic [31:0] d);
        int          n;
        int          o;
        int          idx;
        logic [31:0] r;
        n   = (l == 2'd0) ? 4 : int'(l);
        o   = int'(a % 4);
        idx = int'((a / 4) % c_words);
        r   = 32'd0;
        if (t > 3'd2 || (o + n) > 4) return 32'd0;
        for (int i = 0; i < n; i++) begin
            if (t == c_read) r[8*i +: 8] = mdl[idx][8*(o+i) +: 8];
            else             mdl[idx][8*(o+i) +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Response monitor: handshake happens at the next rising edge.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (reset_n === 1'b1 && bus.resp_val === 1'b1 && bus.resp_rdy === 1'b1) begin
            got = {bus.resp_type, bus.resp_opaque, bus.resp_len, bus.resp_data};
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL stale_resp: observed opaque=%0d data=0x%08h expected no response",
                       got.o, got.d);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                assert (got === e) else begin
                    n_err++;
                    $error("FAIL resp: observed t=%0d o=%0d l=%0d d=0x%08h expected t=%0d o=%0d l=%0d d=0x%08h",
                           got.t, got.o, got.l, got.d, e.t, e.o, e.l, e.d);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one request; returns 1 time unit after its accept edge.
    task automatic send(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                        input logic [1:0] l, input logic [31:0] d);
        exp_t e;
        int   n;
        bus.req_type   = t;
        bus.req_opaque = o;
        bus.req_addr   = a;
        bus.req_len    = l;
        bus.req_data   = d;
        bus.req_val    = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.req_rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $error("FAIL send_timeout: observed req_rdy=%b expected 1 within 200 cycles", bus.req_rdy);
        end else begin
            e.t = t; e.o = o; e.l = l;
            e.d = model(t, a, l, d);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_val = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          c0;
        int          acc;
        logic [7:0]  op;
        exp_t        e;

        reset_n        = 1'b0;
        bus.req_val    = 1'b0;
        bus.req_type   = 3'd0;
        bus.req_opaque = 8'd0;
        bus.req_addr   = 32'd0;
        bus.req_len    = 2'd0;
        bus.req_data   = 32'd0;
        bus.resp_rdy   = 1'b1;

        idle(2);
        chk("reset_req_rdy",  32'(bus.req_rdy),  32'd0);
        chk("reset_resp_val", 32'(bus.resp_val), 32'd0);
        chk("reset_err",      32'(bus.err),      32'd0);
        reset_n = 1'b1;
        idle(1);
        chk("post_reset_req_rdy", 32'(bus.req_rdy), 32'd1);

        // T2: full-word write then read of the same word next cycle
        send(c_write, 8'h01, 32'h10, 2'd0, 32'hDEADBEEF);
        send(c_read,  8'h02, 32'h10, 2'd0, 32'd0);
        idle(4);
        send(c_read,  8'h03, 32'h10, 2'd0, 32'd0);
        k = 0;
        while (bus.resp_val !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("t2_latency_edges", 32'(k), 32'(c_lat - 1));
        idle(4);
        chk("t2_drained", 32'(sb.size()), 32'd0);

        // T3: byte write into lane 1, then word and top-byte reads
        send(c_write, 8'h04, 32'h11, 2'd1, 32'h0000005A);
        send(c_read,  8'h05, 32'h10, 2'd0, 32'd0);
        send(c_read,  8'h06, 32'h13, 2'd1, 32'd0);
        idle(4);

        // T4: misaligned span and illegal type both error with data 0
        chk("t4_err_before", 32'(bus.err), 32'd0);
        send(c_read, 8'h07, 32'h12, 2'd3, 32'd0);
        idle(4);
        chk("t4_err_span", 32'(bus.err), 32'd1);
        send(3'd5, 8'h08, 32'h10, 2'd0, 32'h12345678);
        send(c_write, 8'h09, 32'h13, 2'd2, 32'hFFFFFFFF);
        idle(4);
        chk("t4_err_sticky", 32'(bus.err), 32'd1);
        send(c_read, 8'h0A, 32'h10, 2'd0, 32'd0);

        // T6: address above the array wraps onto word 2
        send(c_write, 8'h0B, 32'(4*c_words + 8), 2'd0, 32'h00000001);
        send(c_read,  8'h0C, 32'h8, 2'd0, 32'd0);
        idle(4);

        // T5: back-to-back reads at full rate
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send(c_read, 8'(i), 32'h10, 2'd0, 32'd0);
        end
        chk("t5_accept_cycles", 32'(cyc - c0), 32'd8);
        idle(c_lat);
        chk("t5_all_resp_in_time", 32'(sb.size()), 32'd0);

        // T5: stalled consumer, credits cap outstanding requests
        bus.resp_rdy   = 1'b0;
        bus.req_type   = c_read;
        bus.req_addr   = 32'h10;
        bus.req_len    = 2'd0;
        bus.req_data   = 32'd0;
        op             = 8'h20;
        bus.req_opaque = op;
        bus.req_val    = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req_rdy === 1'b1) begin
                e.t = c_read; e.o = op; e.l = 2'd0;
                e.d = model(c_read, 32'h10, 2'd0, 32'd0);
                sb.push_back(e);
                acc++;
                op = op + 8'd1;
            end
            @(posedge clk);
            #1;
            bus.req_opaque = op;
        end
        bus.req_val = 1'b0;
        chk("t5_accepts_when_stalled", 32'(acc), 32'(c_depth));
        chk("t5_req_rdy_low", 32'(bus.req_rdy), 32'd0);
        chk("t5_hold_val", 32'(bus.resp_val), 32'd1);
        chk("t5_hold_opaque_a", 32'(bus.resp_opaque), 32'(sb[0].o));
        idle(2);
        chk("t5_hold_opaque_b", 32'(bus.resp_opaque), 32'(sb[0].o));
        chk("t5_hold_data", bus.resp_data, sb[0].d);
        bus.resp_rdy = 1'b1;
        idle(6);
        chk("t5_drained", 32'(sb.size()), 32'd0);

        // T1: reset with two requests outstanding
        bus.resp_rdy = 1'b0;
        send(c_read, 8'h30, 32'h10, 2'd0, 32'd0);
        send(c_read, 8'h31, 32'h8,  2'd0, 32'd0);
        idle(2);
        chk("t1_outstanding_val", 32'(bus.resp_val), 32'd1);
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("t1_rst_req_rdy",  32'(bus.req_rdy),     32'd0);
        chk("t1_rst_resp_val", 32'(bus.resp_val),    32'd0);
        chk("t1_rst_opaque",   32'(bus.resp_opaque), 32'd0);
        chk("t1_rst_data",     bus.resp_data,        32'd0);
        chk("t1_rst_err",      32'(bus.err),         32'd0);
        idle(2);
        reset_n      = 1'b1;
        bus.resp_rdy = 1'b1;
        idle(1);
        chk("t1_req_rdy_after", 32'(bus.req_rdy), 32'd1);
        idle(5);
        chk("t1_no_stale", 32'(bus.resp_val), 32'd0);
        send(c_read, 8'h40, 32'h10, 2'd0, 32'd0);
        send(c_read, 8'h41, 32'h8,  2'd0, 32'd0);
        idle(5);
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
